// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU (shift-add / restoring division) plus MTHI/MTLO writes.
module mult_div_unit #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [1:0] OpDiv = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               aneg_q, aneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // op[0]==0 selects the signed variants; 0x8000_0000 negates to itself, read as unsigned.
    assign a_neg = ~op[0] & src_a[WIDTH-1];
    assign b_neg = ~op[0] & src_b[WIDTH-1];
    assign a_mag = a_neg ? (~src_a + 1'b1) : src_a;
    assign b_mag = b_neg ? (~src_b + 1'b1) : src_b;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? bmag_q : '0)};
    assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, bmag_q};

    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_fix = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = aneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bmag_d  = bmag_q;
        op_d    = op_q;
        neg_d   = neg_q;
        aneg_d  = aneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    neg_d   = a_neg ^ b_neg;
                    aneg_d  = a_neg;
                    bmag_d  = b_mag;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    cnt_d   = '0;
                    state_d = StRun;
                end else if (hilo_we) begin
                    if (hilo_sel) hi_d = src_a;
                    else          lo_d = src_a;
                end
            end
            StRun: begin
                if (op_q[1]) begin
                    // Restoring step: remainder in the upper half, quotient bits shift in at bit 0.
                    if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else                  acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                if (op_q[1]) begin
                    lo_d = (bmag_q == '0) ? DIV0_QUOT : quot_fix;
                    hi_d = (op_q == OpDiv) ? rem_fix : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            bmag_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bmag_q  <= bmag_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            aneg_q  <= aneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
